store_result_monitor: RTL and testbench
=======================================

# store_result_monitor

Synthesizable monitor on the processor's data-memory write bus, downstream of `top` in parallel with data memory. It consumes `MemWrite`, `DataAdr` and `WriteData` and records a trace of the most recent stores. It issues a pass/fail/timeout verdict when the program stores to the result address, so the self-check runs on FPGA without a simulator.

## Interface
- `MON_ADDR`, default 32'd128: verdict address.
- `EXPECT`, default 32'hFE: value required at `MON_ADDR` for pass.
- `DEPTH`, default 4: trace ring-buffer entries, power of two, ≥2.
- `TIMEOUT`, default 1000: clock edges in RUN before timeout; 0 disables timeout.
- `clk` input 1: processor clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `MemWrite` input 1: store strobe from the processor.
- `DataAdr` input 32: store address.
- `WriteData` input 32: store data.
- `done` output 1: verdict reached (sticky).
- `pass` output 1: verdict store matched `EXPECT` (sticky).
- `fail` output 1: verdict store mismatched `EXPECT` (sticky).
- `timeout` output 1: `TIMEOUT` reached without a verdict store (sticky).
- `cycles` output 32: edges counted in RUN, frozen at the verdict.
- `trace_count` output $clog2(DEPTH)+1: valid trace entries, saturating at `DEPTH`.
- `rd_idx` input $clog2(DEPTH): trace read index; 0 = most recent store.
- `rd_adr` output 32: address of the trace entry at `rd_idx`.
- `rd_data` output 32: data of the trace entry at `rd_idx`.

## Operation
- **States.**
  - Two-state FSM: RUN and HALT; reset enters RUN.
  - HALT is left only by reset.
- **Store qualification.** A store is qualified when `MemWrite`=1 at a rising edge; it is sampled at that edge.
- **Store in RUN.**
  - The store's {`DataAdr`, `WriteData`} is written to the ring buffer at the write pointer.
  - The pointer increments modulo `DEPTH`, wrapping and overwriting the oldest entry.
  - `trace_count` increments, saturating at `DEPTH`.
- **Verdict store.**
  - Defined as a store in RUN with `DataAdr`===`MON_ADDR`; it is logged like any other store.
  - FSM goes to HALT and `done` is set.
  - `pass` is set if `WriteData`===`EXPECT`; otherwise `fail` is set.
- **Cycle counting.**
  - In RUN, `cycles` increments on every edge, including the verdict edge.
  - Saturates at 32'hFFFF_FFFF.
- **Timeout.**
  - Condition: `TIMEOUT`≠0, the edge would make `cycles`==`TIMEOUT`, and no verdict store at that edge.
  - Result: HALT with `done`=1 and `timeout`=1.
  - A verdict store at the same edge has priority: pass/fail, never timeout.
- **HALT.** All stores are ignored; trace, `trace_count` and `cycles` are frozen.
- **Trace read.**
  - Combinational: `rd_adr`/`rd_data` = entry at (wr_ptr − 1 − `rd_idx`) mod `DEPTH`.
  - If `rd_idx` ≥ `trace_count`, both read 0.
- **Exclusivity.** `pass`, `fail` and `timeout` are mutually exclusive; `done` = `pass` | `fail` | `timeout`.

## Timing
- **Reset values.**
  - `reset`=0 asynchronously clears all outputs and state to 0: `done`, `pass`, `fail`, `timeout`, `cycles`, `trace_count`, write pointer and buffer contents.
  - Consequently `rd_adr`=`rd_data`=0.
- **Reset release.** The first counted edge is the first rising edge with `reset`=1.
- **Latency.** A store sampled at edge k is visible on the trace read port, `trace_count`, and `done`/`pass`/`fail` immediately after edge k: registered, zero extra cycles.
- **Mid-operation reset.** Reset asserted mid-run or in HALT aborts immediately. The next run starts from an empty trace with `cycles`=0.
- **No stalls.** The block never stalls the processor and has no backpressure. One store per edge is accepted.
- **Non-store edges.** `MemWrite` with X/Z on `DataAdr` is not a verdict store (=== compare); it is still logged if `MemWrite`===1.
- **Wrap example (`DEPTH`=4).** After 5 stores, entries hold stores 2..5; `rd_idx`=0 returns store 5 and `rd_idx`=3 returns store 2.

## Test plan
- **Pass.** Release reset, 3 stores (adr 100/104/108), then at edge 10 store adr 128 data 32'hFE. Expect:
  - `done`=`pass`=1, `fail`=`timeout`=0, `cycles`=10.
  - `trace_count`=4; `rd_idx`=0 gives adr 128 data FE.
- **Fail and freeze.** Store adr 128 data 32'h7. Expect `fail`=1, `pass`=0. A subsequent store to adr 128 data FE leaves `fail`=1, `pass`=0, and `trace_count`/`cycles` unchanged.
- **Wrap-around.** 6 stores with data 1..6 to adr 64, no verdict. Expect:
  - `trace_count`=4.
  - `rd_idx`=0..3 gives data 6,5,4,3; `rd_idx`=3 never returns 1 or 2.
- **Timeout and tie.**
  - With `TIMEOUT`=20 and no stores: `timeout`=1 after edge 20, `cycles`=20.
  - Rerun with the verdict store (FE) at edge 20: `pass`=1, `timeout`=0.
- **Mid-run reset.** Assert `reset`=0 between edges after 2 stores, before any edge. All outputs go 0 immediately. After release, a store to 128/FE gives `pass` with `trace_count`=1 and `cycles`=1.
- **Non-verdict addresses.** Stores to adr 132 and 124 with data FE give no verdict; `done` stays 0.

Source files
------------

// File: rtl/store_result_monitor.sv
// -----------------------------------------------------------------------------
// store_result_monitor
//
// Watches the processor's data-memory write bus and keeps a ring-buffer trace
// of the most recent stores. When the program stores to MON_ADDR, the monitor
// halts with a pass or fail verdict, depending on whether the stored value
// equals EXPECT. If TIMEOUT edges pass without that store, it halts with a
// timeout verdict instead. Once halted, the trace, trace_count and cycles keep
// their values until reset.
//
// Parameters:
//   MON_ADDR    verdict address
//   EXPECT      value at MON_ADDR that means pass
//   DEPTH       trace entries (power of two, >= 2)
//   TIMEOUT     edges in RUN before timeout; 0 disables the timeout
//
// Ports:
//   clk         processor clock, rising edge
//   reset       asynchronous, active-low reset
//   MemWrite    store strobe
//   DataAdr     store address
//   WriteData   store data
//   done        verdict reached (sticky)
//   pass        verdict store matched EXPECT (sticky)
//   fail        verdict store did not match EXPECT (sticky)
//   timeout     TIMEOUT reached with no verdict store (sticky)
//   cycles      edges counted in RUN; frozen in HALT
//   trace_count number of valid trace entries, saturating at DEPTH
//   rd_idx      trace read index; 0 = most recent store
//   rd_adr      address of the selected trace entry (0 if not valid)
//   rd_data     data of the selected trace entry (0 if not valid)
// -----------------------------------------------------------------------------
module store_result_monitor #(
   parameter logic [31:0] MON_ADDR = 32'd128,
   parameter logic [31:0] EXPECT   = 32'hFE,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TIMEOUT  = 1000,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned CW      = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          MemWrite,
   input  logic [31:0]   DataAdr,
   input  logic [31:0]   WriteData,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          timeout,
   output logic [31:0]   cycles,
   output logic [CW-1:0] trace_count,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_adr,
   output logic [31:0]   rd_data
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   cycles_q, cycles_d;
   logic          pass_q, pass_d;
   logic          fail_q, fail_d;
   logic          timeout_q, timeout_d;

   logic [31:0]   adr_mem_q  [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];

   logic          in_run;
   logic          store_vld;
   logic          verdict;
   logic          hit_timeout;
   logic [31:0]   cycles_inc;
   logic [AW-1:0] rd_ptr;
   logic          rd_valid;

   // Next-state logic for the control registers.
   always_comb begin
      in_run      = (state_q == ST_RUN);
      // A 4-state compare makes X/Z on the strobe or the address behave as
      // "no store" or "not the verdict address" in simulation.
      store_vld   = in_run && (MemWrite === 1'b1);
      verdict     = store_vld && (DataAdr === MON_ADDR);
      cycles_inc  = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
      // A verdict store on the same edge takes priority over the timeout.
      hit_timeout = (TIMEOUT != 0) && in_run && (cycles_inc == TIMEOUT) && !verdict;

      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      cycles_d  = cycles_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      timeout_d = timeout_q;

      if (in_run) begin
         cycles_d = cycles_inc;
         if (store_vld) begin
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != CW'(DEPTH)) begin
               count_d = count_q + CW'(1);
            end
         end
         if (verdict) begin
            state_d = ST_HALT;
            if (WriteData === EXPECT) begin
               pass_d = 1'b1;
            end else begin
               fail_d = 1'b1;
            end
         end else if (hit_timeout) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         cycles_q  <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         cycles_q  <= cycles_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
      end
   end

   // The trace is a small register file rather than block RAM. It must clear
   // on reset and be read combinationally.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_en;
      assign wr_en = store_vld && (wr_ptr_q == AW'(gi));

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            adr_mem_q[gi]  <= '0;
            data_mem_q[gi] <= '0;
         end else if (wr_en) begin
            adr_mem_q[gi]  <= DataAdr;
            data_mem_q[gi] <= WriteData;
         end
      end
   end

   // The newest entry is one slot behind the write pointer. rd_idx counts
   // backwards from that entry.
   always_comb begin
      rd_ptr   = wr_ptr_q - AW'(1) - rd_idx;
      rd_valid = ({1'b0, rd_idx} < count_q);
      rd_adr   = rd_valid ? adr_mem_q[rd_ptr]  : 32'd0;
      rd_data  = rd_valid ? data_mem_q[rd_ptr] : 32'd0;
   end

   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign done        = pass_q | fail_q | timeout_q;
   assign cycles      = cycles_q;
   assign trace_count = count_q;

endmodule

// File: tb/tb_store_result_monitor.sv
// -----------------------------------------------------------------------------
// tb_store_result_monitor
//
// Self-checking bench for store_result_monitor, built with TIMEOUT=20 and the
// other parameters at their defaults. When a store is driven that the monitor
// should log, the bench pushes its {address, data} onto a scoreboard queue.
// After the edge, it pops the entry and compares it with trace entry 0.
// Each scenario task also checks the verdict flags, cycles, trace_count and
// the trace contents against fixed expected values.
// -----------------------------------------------------------------------------
module tb_store_result_monitor;

   localparam logic [31:0] MON = 32'd128;
   localparam logic [31:0] EXP = 32'hFE;
   localparam int unsigned TO  = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic [1:0]  rd_idx = '0;
   logic        done, pass, fail, timeout;
   logic [31:0] cycles;
   logic [2:0]  trace_count;
   logic [31:0] rd_adr, rd_data;

   int checks = 0;
   int errors = 0;

   // Scoreboard of logged stores still waiting for their read-back.
   logic [63:0] exp_q[$];
   // Run/halt state as the bench expects it, used to decide which stores are logged.
   bit          m_run;
   logic [31:0] m_cyc;

   store_result_monitor #(
      .MON_ADDR (MON),
      .EXPECT   (EXP),
      .DEPTH    (4),
      .TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .cycles      (cycles),
      .trace_count (trace_count),
      .rd_idx      (rd_idx),
      .rd_adr      (rd_adr),
      .rd_data     (rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      reset    = 1'b0;
      MemWrite = 1'b0;
      rd_idx   = '0;
      exp_q.delete();
      m_run = 1'b1;
      m_cyc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Drive one edge, optionally with a store. Then check trace entry 0
   // against the scoreboard.
   task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      logic [63:0] e;
      MemWrite  = we;
      DataAdr   = adr;
      WriteData = dat;
      if (we && m_run) exp_q.push_back({adr, dat});
      if (m_run) begin
         m_cyc = m_cyc + 32'd1;
         if (we && adr == MON) m_run = 1'b0;
         else if (m_cyc == TO) m_run = 1'b0;
      end
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rd_idx = 2'd0;
         #1;
         checks++;
         if ({rd_adr, rd_data} !== e) begin
            errors++;
            $display("FAIL sb_trace0 got adr=%0d data=%h want adr=%0d data=%h", rd_adr, rd_data, e[63:32], e[31:0]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if ({pass, fail, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {pass, fail, timeout}); end
      checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", cycles); end
      checks++; if (trace_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", trace_count); end
      checks++; if ({rd_adr, rd_data} !== 64'd0) begin errors++; $display("FAIL reset_rd got %h want 0", {rd_adr, rd_data}); end
      $display("txn reset: done=%b cycles=%0d count=%0d", done, cycles, trace_count);
   endtask

   task automatic test_pass();
      apply_reset();
      step(1'b1, 32'd100, 32'h11);
      step(1'b1, 32'd104, 32'h22);
      step(1'b1, 32'd108, 32'h33);
      repeat (6) step(1'b0, 32'd0, 32'd0);
      step(1'b1, MON, EXP);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got %b want 1", done); end
      checks++; if ({pass, fail, timeout} !== 3'b100) begin errors++; $display("FAIL pass_flags got %b want 100", {pass, fail, timeout}); end
      checks++; if (cycles !== 32'd10) begin errors++; $display("FAIL pass_cycles got %0d want 10", cycles); end
      checks++; if (trace_count !== 3'd4) begin errors++; $display("FAIL pass_count got %0d want 4", trace_count); end
      rd_idx = 2'd3; #1;
      checks++; if (rd_adr !== 32'd100 || rd_data !== 32'h11) begin errors++; $display("FAIL pass_rd3 got %0d/%h want 100/11", rd_adr, rd_data); end
      rd_idx = 2'd0;
      $display("txn pass: pass=%b cycles=%0d count=%0d", pass, cycles, trace_count);
   endtask

   task automatic test_fail_freeze();
      apply_reset();
      step(1'b1, MON, 32'h7);
      checks++; if ({pass, fail, timeout, done} !== 4'b0101) begin errors++; $display("FAIL fail_flags got %b want 0101", {pass, fail, timeout, done}); end
      step(1'b1, MON, EXP);
      step(1'b0, 32'd0, 32'd0);
      checks++; if ({pass, fail} !== 2'b01) begin errors++; $display("FAIL freeze_flags got %b want 01", {pass, fail}); end
      checks++; if (trace_count !== 3'd1) begin errors++; $display("FAIL freeze_count got %0d want 1", trace_count); end
      checks++; if (cycles !== 32'd1) begin errors++; $display("FAIL freeze_cycles got %0d want 1", cycles); end
      checks++; if (rd_data !== 32'h7) begin errors++; $display("FAIL freeze_rd0 got %h want 7", rd_data); end
      rd_idx = 2'd1; #1;
      checks++; if ({rd_adr, rd_data} !== 64'd0) begin errors++; $display("FAIL freeze_rd_invalid got %h want 0", {rd_adr, rd_data}); end
      rd_idx = 2'd0;
      $display("txn fail_freeze: fail=%b pass=%b cycles=%0d", fail, pass, cycles);
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 1; i <= 6; i++) step(1'b1, 32'd64, 32'(i));
      checks++; if (trace_count !== 3'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", trace_count); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrap_done got %b want 0", done); end
      for (int i = 0; i < 4; i++) begin
         rd_idx = 2'(i); #1;
         checks++;
         if (rd_adr !== 32'd64 || rd_data !== 32'(6 - i)) begin
            errors++; $display("FAIL wrap_rd%0d got %0d/%0d want 64/%0d", i, rd_adr, rd_data, 6 - i);
         end
      end
      rd_idx = 2'd0;
      $display("txn wrap: count=%0d", trace_count);
   endtask

   task automatic test_timeout();
      apply_reset();
      repeat (19) step(1'b0, 32'd0, 32'd0);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_early_done got %b want 0", done); end
      step(1'b0, 32'd0, 32'd0);
      checks++; if ({pass, fail, timeout, done} !== 4'b0011) begin errors++; $display("FAIL to_flags got %b want 0011", {pass, fail, timeout, done}); end
      checks++; if (cycles !== 32'd20) begin errors++; $display("FAIL to_cycles got %0d want 20", cycles); end
      repeat (3) step(1'b0, 32'd0, 32'd0);
      checks++; if (cycles !== 32'd20) begin errors++; $display("FAIL to_frozen got %0d want 20", cycles); end
      $display("txn timeout: timeout=%b cycles=%0d", timeout, cycles);
   endtask

   task automatic test_tie();
      apply_reset();
      repeat (19) step(1'b0, 32'd0, 32'd0);
      step(1'b1, MON, EXP);
      checks++; if ({pass, fail, timeout} !== 3'b100) begin errors++; $display("FAIL tie_flags got %b want 100", {pass, fail, timeout}); end
      checks++; if (cycles !== 32'd20) begin errors++; $display("FAIL tie_cycles got %0d want 20", cycles); end
      $display("txn tie: pass=%b timeout=%b", pass, timeout);
   endtask

   task automatic test_midrun_reset();
      apply_reset();
      step(1'b1, 32'd200, 32'h5);
      step(1'b1, 32'd204, 32'h6);
      reset = 1'b0;
      exp_q.delete();
      m_run = 1'b1;
      m_cyc = '0;
      #1;
      checks++; if (trace_count !== 3'd0 || cycles !== 32'd0) begin errors++; $display("FAIL mid_clear got count=%0d cycles=%0d want 0/0", trace_count, cycles); end
      checks++; if ({rd_adr, rd_data} !== 64'd0) begin errors++; $display("FAIL mid_rd got %h want 0", {rd_adr, rd_data}); end
      #1;
      reset = 1'b1;
      step(1'b1, MON, EXP);
      checks++; if ({pass, done} !== 2'b11) begin errors++; $display("FAIL mid_pass got %b want 11", {pass, done}); end
      checks++; if (trace_count !== 3'd1 || cycles !== 32'd1) begin errors++; $display("FAIL mid_after got count=%0d cycles=%0d want 1/1", trace_count, cycles); end
      $display("txn midrun_reset: pass=%b count=%0d cycles=%0d", pass, trace_count, cycles);
   endtask

   task automatic test_non_verdict();
      apply_reset();
      step(1'b1, 32'd132, EXP);
      step(1'b1, 32'd124, EXP);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL nv_done got %b want 0", done); end
      checks++; if (trace_count !== 3'd2) begin errors++; $display("FAIL nv_count got %0d want 2", trace_count); end
      $display("txn non_verdict: done=%b count=%0d", done, trace_count);
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail_freeze();
      test_wrap();
      test_timeout();
      test_tie();
      test_midrun_reset();
      test_non_verdict();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
